id_ex_operand_stage: RTL and testbench

ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

---
 rtl/id_ex_operand_stage_pkg.sv | 24 ++
 rtl/id_ex_operand_stage_fwd_mux.sv | 32 +++
 rtl/id_ex_operand_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: widths, ALU op codes,
// skid-buffer state encoding and op-code legality helper.
package id_ex_operand_stage_pkg;

   localparam int unsigned DW_DEF = 32;
   localparam int unsigned RW_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0010,
      ALU_SLT = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

   function automatic logic op_legal(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
   endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM over MEM/WB over register-file data.
// Register 0 is hardwired and is never forwarded.
module fwd_mux
   import id_ex_operand_stage_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic [RW-1:0] addr,
   input  logic [DW-1:0] rf_val,
   input  logic          exm_wr,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_data,
   input  logic          wb_wr,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   output logic [DW-1:0] val
);

   // Priority select of the freshest producer for this source address
   always_comb begin
      val = rf_val;
      if (addr != '0) begin
         if (exm_wr && (exm_rd == addr)) begin
            val = exm_data;
         end else if (wb_wr && (wb_rd == addr)) begin
            val = wb_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves forwarding and immediate selection at
// accept time and holds up to two entries in a skid buffer. Outputs are
// the head entry registers; in_ready is registered (no path from out_ready).
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned RW = RW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_rs_val,
   input  logic [DW-1:0] in_rt_val,
   input  logic [RW-1:0] in_rs,
   input  logic [RW-1:0] in_rt,
   input  logic [RW-1:0] in_rd,
   input  logic [15:0]   in_imm,
   input  logic          in_alu_src,
   input  logic          in_sign_ext,
   input  logic [3:0]    in_alu_op,
   input  logic          exm_wr,
   input  logic [RW-1:0] exm_rd,
   input  logic [DW-1:0] exm_data,
   input  logic          wb_wr,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b,
   output logic [3:0]    out_alu_op,
   output logic [RW-1:0] out_rd,
   output logic          out_bad_op
);

   state_e        state;
   logic [DW-1:0] skid_a, skid_b;
   logic [3:0]    skid_op;
   logic [RW-1:0] skid_rd;
   logic          skid_bad;

   logic [DW-1:0] fwd_rs, fwd_rt, imm_ext;
   logic [DW-1:0] cap_a, cap_b;
   logic [3:0]    cap_op;
   logic          cap_bad;
   logic          accept, issue;

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
      .addr(in_rs), .rf_val(in_rs_val),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
      .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
      .val(fwd_rs)
   );

   fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
      .addr(in_rt), .rf_val(in_rt_val),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
      .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
      .val(fwd_rt)
   );

   // Build the entry that would be captured if accepted this cycle
   always_comb begin
      accept  = in_valid && in_ready;
      issue   = out_valid && out_ready;
      imm_ext = in_sign_ext ? {{(DW-16){in_imm[15]}}, in_imm}
                            : {{(DW-16){1'b0}}, in_imm};
      cap_a   = fwd_rs;
      cap_b   = in_alu_src ? imm_ext : fwd_rt;
      cap_bad = !op_legal(in_alu_op);
      cap_op  = cap_bad ? ALU_ADD : in_alu_op;
   end

   // Skid-buffer FSM with registered head outputs and registered handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_a      <= '0;
         out_b      <= '0;
         out_alu_op <= '0;
         out_rd     <= '0;
         out_bad_op <= 1'b0;
         skid_a     <= '0;
         skid_b     <= '0;
         skid_op    <= '0;
         skid_rd    <= '0;
         skid_bad   <= 1'b0;
      end else if (flush) begin
         // same-cycle accept is dropped; a same-cycle issue has already happened downstream
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  out_a      <= cap_a;
                  out_b      <= cap_b;
                  out_alu_op <= cap_op;
                  out_rd     <= in_rd;
                  out_bad_op <= cap_bad;
                  out_valid  <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !issue) begin
                  skid_a   <= cap_a;
                  skid_b   <= cap_b;
                  skid_op  <= cap_op;
                  skid_rd  <= in_rd;
                  skid_bad <= cap_bad;
                  in_ready <= 1'b0;
                  state    <= ST_FULL;
               end else if (accept && issue) begin
                  out_a      <= cap_a;
                  out_b      <= cap_b;
                  out_alu_op <= cap_op;
                  out_rd     <= in_rd;
                  out_bad_op <= cap_bad;
               end else if (issue) begin
                  out_valid <= 1'b0;
                  state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (issue) begin
                  out_a      <= skid_a;
                  out_b      <= skid_b;
                  out_alu_op <= skid_op;
                  out_rd     <= skid_rd;
                  out_bad_op <= skid_bad;
                  in_ready   <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority,
// immediate extension, backpressure, bad op codes, flush and async reset.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready;
   logic [31:0] in_rs_val, in_rt_val, exm_data, wb_data;
   logic [4:0]  in_rs, in_rt, in_rd, exm_rd, wb_rd;
   logic [15:0] in_imm;
   logic        in_alu_src, in_sign_ext, exm_wr, wb_wr;
   logic [3:0]  in_alu_op;
   logic        out_valid, out_ready, out_bad_op;
   logic [31:0] out_a, out_b;
   logic [3:0]  out_alu_op;
   logic [4:0]  out_rd;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_imm(in_imm), .in_alu_src(in_alu_src), .in_sign_ext(in_sign_ext),
      .in_alu_op(in_alu_op),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
      .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_alu_op(out_alu_op),
      .out_rd(out_rd), .out_bad_op(out_bad_op)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a register-register instruction with no forwarding sources active
   task automatic offer(input logic [31:0] rs_val, input logic [31:0] rt_val,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [3:0] op);
      in_valid   = 1'b1;
      in_rs_val  = rs_val;
      in_rt_val  = rt_val;
      in_rs      = rs;
      in_rt      = rt;
      in_rd      = rd;
      in_alu_op  = op;
      in_alu_src = 1'b0;
      in_sign_ext = 1'b0;
      in_imm     = 16'h0000;
      exm_wr     = 1'b0;
      wb_wr      = 1'b0;
      exm_rd     = 5'd0;
      wb_rd      = 5'd0;
      exm_data   = 32'h0;
      wb_data    = 32'h0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      offer(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'b0000);
      in_valid = 1'b0;
      tick(); tick();
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_a", out_a, 32'h0);
      chk("rst_out_b", out_b, 32'h0);
      chk("rst_out_op", {28'b0, out_alu_op}, 32'h0);
      chk("rst_out_bad", {31'b0, out_bad_op}, 32'h0);

      // First edge with rst_n high accepts
      rst_n = 1'b1;
      offer(32'd5, 32'd3, 5'd1, 5'd2, 5'd4, 4'b0010);
      tick();
      in_valid = 1'b0;
      chk("basic_valid", {31'b0, out_valid}, 32'd1);
      chk("basic_a", out_a, 32'd5);
      chk("basic_b", out_b, 32'd3);
      chk("basic_op", {28'b0, out_alu_op}, 32'h2);
      chk("basic_rd", {27'b0, out_rd}, 32'd4);
      chk("basic_bad", {31'b0, out_bad_op}, 32'd0);
      tick();
      chk("basic_drained", {31'b0, out_valid}, 32'd0);

      // Forwarding priority: EX/MEM beats WB beats register file
      offer(32'h11, 32'h22, 5'd7, 5'd9, 5'd3, 4'b0000);
      exm_wr = 1'b1; exm_rd = 5'd7; exm_data = 32'hAA;
      wb_wr  = 1'b1; wb_rd  = 5'd7; wb_data  = 32'hBB;
      tick(); in_valid = 1'b0;
      chk("fwd_exm_a", out_a, 32'hAA);
      chk("fwd_exm_b_rf", out_b, 32'h22);
      tick();
      offer(32'h11, 32'h22, 5'd7, 5'd9, 5'd3, 4'b0000);
      wb_wr = 1'b1; wb_rd = 5'd9; wb_data = 32'hBB;
      exm_wr = 1'b1; exm_rd = 5'd8; exm_data = 32'hAA;
      tick(); in_valid = 1'b0;
      chk("fwd_wb_b", out_b, 32'hBB);
      chk("fwd_none_a", out_a, 32'h11);
      tick();
      offer(32'h33, 32'h44, 5'd0, 5'd0, 5'd3, 4'b0000);
      exm_wr = 1'b1; exm_rd = 5'd0; exm_data = 32'hAA;
      wb_wr  = 1'b1; wb_rd  = 5'd0; wb_data  = 32'hBB;
      tick(); in_valid = 1'b0;
      chk("fwd_r0_a", out_a, 32'h33);
      chk("fwd_r0_b", out_b, 32'h44);
      tick();

      // Immediate extension
      offer(32'h1, 32'h99, 5'd1, 5'd2, 5'd3, 4'b0000);
      in_imm = 16'hFFFE; in_alu_src = 1'b1; in_sign_ext = 1'b1;
      tick(); in_valid = 1'b0;
      chk("imm_sext", out_b, 32'hFFFF_FFFE);
      tick();
      offer(32'h1, 32'h99, 5'd1, 5'd2, 5'd3, 4'b0000);
      in_imm = 16'hFFFE; in_alu_src = 1'b1; in_sign_ext = 1'b0;
      tick(); in_valid = 1'b0;
      chk("imm_zext", out_b, 32'h0000_FFFE);
      tick();

      // Backpressure: three offered, two held, issued in order
      out_ready = 1'b0;
      offer(32'hE1, 32'h0, 5'd1, 5'd2, 5'd11, 4'b0000);
      tick();
      chk("bp_ready_one", {31'b0, in_ready}, 32'd1);
      chk("bp_head1", out_a, 32'hE1);
      offer(32'hE2, 32'h0, 5'd1, 5'd2, 5'd12, 4'b0010);
      tick();
      chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
      chk("bp_head_hold", out_a, 32'hE1);
      offer(32'hE3, 32'h0, 5'd1, 5'd2, 5'd13, 4'b1010);
      tick();
      chk("bp_stable_a", out_a, 32'hE1);
      chk("bp_stable_rd", {27'b0, out_rd}, 32'd11);
      chk("bp_stable_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_still_full", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_issue2_a", out_a, 32'hE2);
      chk("bp_issue2_op", {28'b0, out_alu_op}, 32'h2);
      chk("bp_ready_after", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_issue3_a", out_a, 32'hE3);
      chk("bp_issue3_op", {28'b0, out_alu_op}, 32'hA);
      tick();
      chk("bp_empty", {31'b0, out_valid}, 32'd0);

      // Illegal op code
      offer(32'h5, 32'h6, 5'd1, 5'd2, 5'd3, 4'b0111);
      tick(); in_valid = 1'b0;
      chk("bad_op_code", {28'b0, out_alu_op}, 32'h0);
      chk("bad_op_flag", {31'b0, out_bad_op}, 32'd1);
      tick();

      // Flush while FULL with an offered entry
      out_ready = 1'b0;
      offer(32'hF1, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000);
      tick();
      offer(32'hF2, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000);
      tick();
      chk("flush_pre_full", {31'b0, in_ready}, 32'd0);
      offer(32'hF3, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("flush_no_accept", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset while FULL
      offer(32'hD1, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000);
      tick();
      offer(32'hD2, 32'h0, 5'd1, 5'd2, 5'd3, 4'b0000);
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_ready", {31'b0, in_ready}, 32'd1);
      chk("arst_a", out_a, 32'h0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      offer(32'hC0, 32'h0, 5'd1, 5'd2, 5'd6, 4'b0000);
      tick();
      in_valid = 1'b0;
      chk("arst_first_valid", {31'b0, out_valid}, 32'd1);
      chk("arst_first_a", out_a, 32'hC0);
      tick();
      chk("arst_no_stale", {31'b0, out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
